// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_queue_if
//  Purpose  : Fetch, resolve and predictor-update bundle for the branch
//             resolve queue, including occupancy and statistics readback.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_queue_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                    fetch_valid;
  logic [ADDR_WIDTH-1:0]   fetch_address;
  logic                    fetch_prediction;
  logic                    fetch_ready;
  logic                    resolve_valid;
  logic                    resolve_taken;
  logic                    update_valid;
  logic [ADDR_WIDTH-1:0]   branch_address;
  logic                    branch_result;
  logic                    mispredict;
  logic                    resolve_err;
  logic [$clog2(DEPTH):0]  occupancy;
  logic [CNT_WIDTH-1:0]    branch_count;
  logic [CNT_WIDTH-1:0]    mispredict_count;

  // Fetch/resolve side driving the queue
  modport master (
    output fetch_valid, fetch_address, fetch_prediction,
    output resolve_valid, resolve_taken,
    input  fetch_ready, update_valid, branch_address, branch_result,
    input  mispredict, resolve_err, occupancy, branch_count, mispredict_count
  );

  // The queue itself
  modport slave (
    input  fetch_valid, fetch_address, fetch_prediction,
    input  resolve_valid, resolve_taken,
    output fetch_ready, update_valid, branch_address, branch_result,
    output mispredict, resolve_err, occupancy, branch_count, mispredict_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_queue
//  Purpose  : In-order queue of predicted branches. On resolution it drives
//             predictor update, flags mispredicts, flushes wrong-path
//             entries and keeps saturating branch/mispredict statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,   // asynchronous, active low
  branch_resolve_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0]     C_FULL    = OCC_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [DEPTH-1:0]      r_mem_pred;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_update_valid;
  logic [ADDR_WIDTH-1:0] r_branch_address;
  logic                  r_branch_result;
  logic                  r_mispredict;
  logic                  r_resolve_err;
  logic [CNT_WIDTH-1:0]  r_branch_count;
  logic [CNT_WIDTH-1:0]  r_mispredict_count;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty_err;
  logic                  w_mis;
  logic [PTR_W-1:0]      w_rd_next;

  assign w_ready     = (r_occ != C_FULL);
  assign w_push      = bus.fetch_valid && w_ready;
  assign w_pop       = bus.resolve_valid && (r_occ != '0);
  assign w_empty_err = bus.resolve_valid && (r_occ == '0);
  assign w_mis       = w_pop && (r_mem_pred[r_rd_ptr] != bus.resolve_taken);
  assign w_rd_next   = r_rd_ptr + 1'b1;

  // Entry storage; a push coinciding with a flush is wrong-path and not kept
  always_ff @(posedge clk) begin
    if (w_push && !w_mis) begin
      r_mem_addr[r_wr_ptr] <= bus.fetch_address;
      r_mem_pred[r_wr_ptr] <= bus.fetch_prediction;
    end
  end

  // Pointers and fill level; a mispredict collapses the queue to empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= w_rd_next;
      if (w_mis) begin
        r_wr_ptr <= w_rd_next;
        r_occ    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      end
    end
  end

  // One-cycle result pulses; address/result hold between updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_update_valid   <= 1'b0;
      r_branch_address <= '0;
      r_branch_result  <= 1'b0;
      r_mispredict     <= 1'b0;
      r_resolve_err    <= 1'b0;
    end else begin
      r_update_valid <= w_pop;
      r_mispredict   <= w_mis;
      r_resolve_err  <= w_empty_err;
      if (w_pop) begin
        r_branch_address <= r_mem_addr[r_rd_ptr];
        r_branch_result  <= bus.resolve_taken;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_pop && (r_branch_count != C_CNT_MAX))
        r_branch_count <= r_branch_count + 1'b1;
      if (w_mis && (r_mispredict_count != C_CNT_MAX))
        r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  assign bus.fetch_ready      = w_ready;
  assign bus.occupancy        = r_occ;
  assign bus.update_valid     = r_update_valid;
  assign bus.branch_address   = r_branch_address;
  assign bus.branch_result    = r_branch_result;
  assign bus.mispredict       = r_mispredict;
  assign bus.resolve_err      = r_resolve_err;
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;
endmodule
`default_nettype wire
